// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store encodings, IO address map and helpers
package lsu_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b011,
    LD_LHU = 3'b100
  } ld_sel_e;

  localparam logic [3:0] BM_SB = 4'b0001;
  localparam logic [3:0] BM_SH = 4'b0011;
  localparam logic [3:0] BM_SW = 4'b1111;

  localparam logic [31:0] ADDR_LEDR  = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG  = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX03 = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX47 = 32'h0000_7024;
  localparam logic [31:0] ADDR_LCD   = 32'h0000_7030;
  localparam logic [31:0] ADDR_SW    = 32'h0000_7800;
  localparam logic [31:0] ADDR_BTN   = 32'h0000_7810;

  typedef enum logic [3:0] {
    REG_DMEM, REG_LEDR, REG_LEDG, REG_HEX03, REG_HEX47,
    REG_LCD, REG_SW, REG_BTN, REG_NONE
  } region_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
    return (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lsu_input_sync.sv
// rtl/lsu_input_sync.sv - multi-flop synchronizer for asynchronous board inputs
module input_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: flop-array DMEM, memory-mapped IO registers, input sync
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES  = 2048,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic        wr_en,
  input  logic [3:0]  bmask,
  input  logic [2:0]  ld_sel,
  output logic [31:0] ld_data,
  output logic        misalign,
  input  logic [31:0] io_sw,
  input  logic [3:0]  io_btn,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [31:0] io_hex03,
  output logic [31:0] io_hex47,
  output logic [31:0] io_lcd
);

  localparam int AW    = $clog2(DMEM_BYTES);
  localparam int WORDS = DMEM_BYTES / 4;

  logic [31:0]   dmem [WORDS];
  logic [31:0]   ledr_q, ledg_q, hex03_q, hex47_q, lcd_q;
  logic [31:0]   sw_s;
  logic [3:0]    btn_s;
  logic [AW-3:0] idx;
  region_e       region;
  size_e         ld_size, st_size;
  logic          ld_mis, do_wr;
  logic [3:0]    wmask;
  logic [31:0]   wdata, rword, shifted;

  input_sync #(.WIDTH(32), .DEPTH(SYNC_STAGES)) u_sw_sync (
    .clk(clk), .rst_n(rst_n), .d(io_sw), .q(sw_s)
  );
  input_sync #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .rst_n(rst_n), .d(io_btn), .q(btn_s)
  );

  assign idx = addr[AW-1:2];

  // DMEM requires all upper address bits clear, so it never aliases into IO space
  always_comb begin
    region = REG_NONE;
    if (addr[31:AW] == '0) begin
      region = REG_DMEM;
    end else begin
      case (addr[31:2])
        ADDR_LEDR[31:2]:  region = REG_LEDR;
        ADDR_LEDG[31:2]:  region = REG_LEDG;
        ADDR_HEX03[31:2]: region = REG_HEX03;
        ADDR_HEX47[31:2]: region = REG_HEX47;
        ADDR_LCD[31:2]:   region = REG_LCD;
        ADDR_SW[31:2]:    region = REG_SW;
        ADDR_BTN[31:2]:   region = REG_BTN;
        default:          region = REG_NONE;
      endcase
    end
  end

  always_comb begin
    ld_size = SZ_BYTE;
    case (ld_sel)
      LD_LW:         ld_size = SZ_WORD;
      LD_LH, LD_LHU: ld_size = SZ_HALF;
      default:       ld_size = SZ_BYTE;
    endcase
    st_size = SZ_BYTE;
    case (bmask)
      BM_SW:   st_size = SZ_WORD;
      BM_SH:   st_size = SZ_HALF;
      BM_SB:   st_size = SZ_BYTE;
      default: st_size = SZ_BYTE;
    endcase
  end

  assign ld_mis   = misaligned(ld_size, addr[1:0]);
  assign misalign = wr_en ? misaligned(st_size, addr[1:0]) : ld_mis;

  always_comb begin
    rword = '0;
    case (region)
      REG_DMEM:  rword = dmem[idx];
      REG_LEDR:  rword = ledr_q;
      REG_LEDG:  rword = ledg_q;
      REG_HEX03: rword = hex03_q;
      REG_HEX47: rword = hex47_q;
      REG_LCD:   rword = lcd_q;
      REG_SW:    rword = sw_s;
      REG_BTN:   rword = {28'd0, btn_s};
      default:   rword = '0;
    endcase
  end

  always_comb begin
    shifted = rword >> {addr[1:0], 3'b000};
    ld_data = '0;
    if (!ld_mis) begin
      case (ld_sel)
        LD_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
        LD_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
        LD_LW:   ld_data = shifted;
        LD_LBU:  ld_data = {24'd0, shifted[7:0]};
        LD_LHU:  ld_data = {16'd0, shifted[15:0]};
        default: ld_data = '0;
      endcase
    end
  end

  assign wmask = bmask << addr[1:0];
  assign wdata = st_data << {addr[1:0], 3'b000};
  assign do_wr = wr_en && !misalign;

  // DMEM shares the async-reset process but is deliberately left out of the reset branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hex03_q <= '0;
      hex47_q <= '0;
      lcd_q   <= '0;
    end else if (do_wr) begin
      case (region)
        REG_DMEM:  dmem[idx] <= merge_bytes(dmem[idx], wdata, wmask);
        REG_LEDR:  ledr_q    <= merge_bytes(ledr_q, wdata, wmask);
        REG_LEDG:  ledg_q    <= merge_bytes(ledg_q, wdata, wmask);
        REG_HEX03: hex03_q   <= merge_bytes(hex03_q, wdata, wmask);
        REG_HEX47: hex47_q   <= merge_bytes(hex47_q, wdata, wmask);
        REG_LCD:   lcd_q     <= merge_bytes(lcd_q, wdata, wmask);
        default:   ;
      endcase
    end
  end

  assign io_ledr  = ledr_q;
  assign io_ledg  = ledg_q;
  assign io_hex03 = hex03_q;
  assign io_hex47 = hex47_q;
  assign io_lcd   = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against a byte-level reference model
module tb_lsu;

  localparam int DMEM_BYTES = 2048;
  localparam int SYNC       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, st_data = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  bmask = 4'hF;
  logic [2:0]  ld_sel = 3'd2;
  logic [31:0] ld_data;
  logic        misalign;
  logic [31:0] io_sw = '0;
  logic [3:0]  io_btn = 4'hA;
  logic [31:0] io_ledr, io_ledg, io_hex03, io_hex47, io_lcd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [DMEM_BYTES];
  logic [31:0] io_m [5];
  logic [31:0] sw_m = '0;

  lsu #(.DMEM_BYTES(DMEM_BYTES), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .st_data(st_data), .wr_en(wr_en),
    .bmask(bmask), .ld_sel(ld_sel), .ld_data(ld_data), .misalign(misalign),
    .io_sw(io_sw), .io_btn(io_btn), .io_ledr(io_ledr), .io_ledg(io_ledg),
    .io_hex03(io_hex03), .io_hex47(io_hex47), .io_lcd(io_lcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // -1 unmapped, 0 DMEM, 1..5 writable IO registers, 6 switches, 7 buttons
  function automatic int reg_of(input logic [31:0] a);
    if (a < DMEM_BYTES) return 0;
    case (a & 32'hFFFF_FFFC)
      32'h7000: return 1;
      32'h7010: return 2;
      32'h7020: return 3;
      32'h7024: return 4;
      32'h7030: return 5;
      32'h7800: return 6;
      32'h7810: return 7;
      default:  return -1;
    endcase
  endfunction

  function automatic logic mis_m(input logic [31:0] a, input int n);
    return (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
  endfunction

  function automatic int ld_bytes(input logic [2:0] s);
    if (s == 3'd2) return 4;
    if (s == 3'd1 || s == 3'd4) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    int r, base;
    r = reg_of(a);
    base = int'(a & 32'hFFFF_FFFC);
    if (r == 0) return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    if (r >= 1 && r <= 5) return io_m[r-1];
    if (r == 6) return sw_m;
    if (r == 7) return {28'd0, io_btn};
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v;
    logic [7:0]  b8;
    logic [15:0] h16;
    if (s > 3'd4 || reg_of(a) < 0 || mis_m(a, ld_bytes(s))) return 32'd0;
    v   = word_of(a) / (32'd1 << (8 * (a % 4)));
    b8  = v[7:0];
    h16 = v[15:0];
    case (s)
      3'd0:    return 32'($signed(b8));
      3'd1:    return 32'($signed(h16));
      3'd3:    return 32'(b8);
      3'd4:    return 32'(h16);
      default: return v;
    endcase
  endfunction

  function automatic int st_bytes(input logic [3:0] bm);
    return (bm == 4'hF) ? 4 : (bm == 4'h3) ? 2 : 1;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
    int n, r, ofs, base;
    n = st_bytes(bm);
    r = reg_of(a);
    if (mis_m(a, n) || r < 0 || r > 5) return;
    ofs  = int'(a % 4);
    base = int'(a & 32'hFFFF_FFFC);
    for (int i = 0; i < n; i++) begin
      if (ofs + i < 4) begin
        if (r == 0) mem_m[base + ofs + i] = d[8*i +: 8];
        else io_m[r-1][8*(ofs+i) +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic check_io(input string tag);
    check({tag, "_ledr"},  io_ledr,  io_m[0]);
    check({tag, "_ledg"},  io_ledg,  io_m[1]);
    check({tag, "_hex03"}, io_hex03, io_m[2]);
    check({tag, "_hex47"}, io_hex47, io_m[3]);
    check({tag, "_lcd"},   io_lcd,   io_m[4]);
  endtask

  // Called at posedge+1; also checks read-during-write returns the pre-store word
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bm);
    addr = a; st_data = d; bmask = bm; wr_en = 1'b1; ld_sel = 3'd2;
    #2;
    check("st_mis", {31'd0, misalign}, {31'd0, mis_m(a, st_bytes(bm))});
    check("st_rdw", ld_data, exp_load(a, 3'd2));
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_store(a, d, bm);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] s);
    addr = a; ld_sel = s; wr_en = 1'b0;
    #2;
    check("ld", ld_data, exp_load(a, s));
    if (s <= 3'd4)
      check("ld_mis", {31'd0, misalign}, {31'd0, mis_m(a, ld_bytes(s))});
    @(posedge clk); #1;
  endtask

  task automatic ld_const(input string tag, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] exp);
    addr = a; ld_sel = s; wr_en = 1'b0;
    #2;
    check(tag, ld_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  bm;
    int          r;
    for (int i = 0; i < 5; i++) io_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_io("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give DMEM a defined starting image
    for (int i = 0; i < DMEM_BYTES / 4; i++) begin
      addr = i * 4; st_data = '0; bmask = 4'hF; wr_en = 1'b1;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < DMEM_BYTES; i++) mem_m[i] = 8'h00;

    store(32'h10, 32'hDEADBEEF, 4'hF);
    ld_const("lb13",  32'h13, 3'd0, 32'hFFFF_FFDE);
    ld_const("lbu13", 32'h13, 3'd3, 32'h0000_00DE);
    ld_const("lhu12", 32'h12, 3'd4, 32'h0000_DEAD);
    ld_const("lh10",  32'h10, 3'd1, 32'hFFFF_BEEF);

    store(32'h20, 32'h0, 4'hF);
    store(32'h22, 32'h1234, 4'h3);
    store(32'h20, 32'hAB, 4'h1);
    ld_const("lw20", 32'h20, 3'd2, 32'h1234_00AB);

    store(32'h7000, 32'h5A, 4'hF);
    check("ledr5a", io_ledr, 32'h5A);
    ld_const("lw7000", 32'h7000, 3'd2, 32'h5A);
    store(32'h7800, 32'hFFFF_FFFF, 4'hF);
    check_io("ro_st");
    ld_const("lw9000", 32'h9000, 3'd2, 32'h0);
    ld_const("alias", 32'h8000_0010, 3'd2, 32'h0);

    store(32'h11, 32'h1111_1111, 4'hF);
    ld_const("mis_keep", 32'h10, 3'd2, 32'hDEAD_BEEF);
    load(32'h21, 3'd1);
    ld_const("lh21", 32'h21, 3'd1, 32'h0);
    store(32'h22, 32'h5678, 4'h3);
    ld_const("badsel", 32'h10, 3'd5, 32'h0);

    // Switch change reaches ld_data exactly SYNC edges later
    io_sw = 32'h3; addr = 32'h7800; ld_sel = 3'd2; wr_en = 1'b0;
    #2;
    check("sync_e0", ld_data, 32'h0);
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(posedge clk); #2;
      check($sformatf("sync_e%0d", k), ld_data, (k >= SYNC) ? 32'h3 : 32'h0);
    end
    @(posedge clk); #1;
    sw_m = 32'h3;

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: a = $urandom_range(0, DMEM_BYTES - 1);
        5: a = 32'h7000 + 32'h10 * $urandom_range(0, 3) + $urandom_range(0, 3);
        6: a = ($urandom_range(0, 1) ? 32'h7800 : 32'h7810) + $urandom_range(0, 3);
        7: a = 32'h9000 + $urandom_range(0, 3);
        8: a = DMEM_BYTES + $urandom_range(0, 15);
        default: a = 32'h8000_0000 | $urandom_range(0, DMEM_BYTES - 1);
      endcase
      if (r == 5 && $urandom_range(0, 3) == 0) a = 32'h7024 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        case ($urandom_range(0, 2))
          0:       bm = 4'h1;
          1:       bm = 4'h3;
          default: bm = 4'hF;
        endcase
        store(a, d, bm);
        check_io("rnd");
      end else begin
        load(a, 3'($urandom_range(0, 7)));
      end
    end

    // Asynchronous reset in mid-cycle while a store is pending
    store(32'h7000, 32'hFF, 4'hF);
    check("ledr_ff", io_ledr, 32'hFF);
    store(32'h40, 32'hCAFE_F00D, 4'hF);
    addr = 32'h7000; st_data = 32'h77; bmask = 4'hF; wr_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) io_m[i] = '0;
    check("rst_now", io_ledr, 32'h0);
    @(posedge clk); #1;
    check("rst_edge", io_ledr, 32'h0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_io("post_rst");
    ld_const("dmem_keep", 32'h40, 3'd2, 32'hCAFE_F00D);
    load(32'h10, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
